// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I/RV64I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// IR latch, immediate generation and retired-instruction counter.
module multicycle_control_unit #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 7,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    output logic               imem_req,
    input  logic               imem_ready,
    output logic               dmem_req,
    input  logic               dmem_ready,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               Branch,
    output logic               Jump,
    output logic               auipc,
    output logic [XLEN-1:0]    imm,
    output logic               ir_write,
    output logic               pc_write,
    output logic               illegal,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic [6:0] opc;
    logic       is_r, is_ia, is_ld, is_st, is_br;
    logic       is_lui, is_aui, is_jal, is_jalr;
    logic       is_ldst, is_jmp, legal;
    logic [2:0] cls;
    logic [2:0] f3;
    logic       b5;
    logic [6:0] aluop_c;
    logic       alusrc_c;
    logic       alu_en;
    logic       imem_req_c;
    logic       ir_wr_c;
    logic signed [31:0] imm32;

    assign opc     = ir_q[6:0];
    assign is_r    = (opc == 7'b0110011);
    assign is_ia   = (opc == 7'b0010011);
    assign is_ld   = (opc == 7'b0000011);
    assign is_st   = (opc == 7'b0100011);
    assign is_br   = (opc == 7'b1100011);
    assign is_lui  = (opc == 7'b0110111);
    assign is_aui  = (opc == 7'b0010111);
    assign is_jal  = (opc == 7'b1101111);
    assign is_jalr = (opc == 7'b1100111);
    assign is_ldst = is_ld | is_st;
    assign is_jmp  = is_jal | is_jalr;
    assign legal   = is_r | is_ia | is_ldst | is_br
                   | is_lui | is_aui | is_jmp;

    always_comb begin
        cls = 3'b000;
        unique case (1'b1)
            is_ia:   cls = 3'b001;
            is_ldst: cls = 3'b010;
            is_br:   cls = 3'b011;
            is_lui:  cls = 3'b100;
            is_aui:  cls = 3'b101;
            is_jmp:  cls = 3'b110;
            default: cls = 3'b000;
        endcase
    end

    // Shift immediates (funct3=101) carry the SRA/SRL select in IR[30].
    assign f3 = (is_r | is_ia | is_br) ? ir_q[14:12] : 3'b000;
    assign b5 = (is_r | (is_ia & (ir_q[14:12] == 3'b101))) & ir_q[30];
    assign aluop_c  = {b5, f3, cls};
    assign alusrc_c = is_ia | is_ldst | is_lui | is_aui | is_jalr;

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            (is_ia | is_ld | is_jalr):
                imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            is_st:
                imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            is_br:
                imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                         ir_q[30:25], ir_q[11:8], 1'b0};
            (is_lui | is_aui):
                imm32 = {ir_q[31:12], 12'b0};
            is_jal:
                imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                         ir_q[20], ir_q[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'(imm32);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        imem_req_c = 1'b0;
        ir_wr_c    = 1'b0;
        dmem_req   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemToReg   = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        pc_write   = 1'b0;
        illegal    = 1'b0;
        alu_en     = 1'b0;
        unique case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_wr_c = 1'b1;
                    ir_d    = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_d = EXEC;
                end else begin
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = FETCH;
                end
            end
            EXEC: begin
                alu_en = 1'b1;
                Jump   = is_jmp;
                if (is_ldst) begin
                    state_d = MEM;
                end else if (is_br) begin
                    Branch    = 1'b1;
                    pc_write  = 1'b1;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                alu_en   = 1'b1;
                dmem_req = 1'b1;
                MemRead  = is_ld;
                MemWrite = is_st;
                pc_write = is_st;
                if (dmem_ready) begin
                    if (is_ld) begin
                        state_d = WB;
                    end else begin
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = FETCH;
                    end
                end
            end
            WB: begin
                alu_en    = 1'b1;
                RegWrite  = 1'b1;
                MemToReg  = is_ld;
                Jump      = is_jmp;
                pc_write  = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Fetch strobes stay quiet while reset is held.
    assign imem_req = imem_req_c & rst_n;
    assign ir_write = ir_wr_c & rst_n;
    assign ALUOp    = alu_en ? ALUOP_W'(aluop_c) : '0;
    assign ALUSrc   = alu_en & alusrc_c;
    assign auipc    = alu_en & is_aui;
    assign state    = state_q;
    assign retired  = retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: per-instruction cycle
// schedules built from the ISA rules, checked every cycle on two instances.
module tb_multicycle_control_unit;

    localparam int C_IREQ = 10;
    localparam int C_DREQ = 9;
    localparam int C_RW   = 8;
    localparam int C_MR   = 7;
    localparam int C_MW   = 6;
    localparam int C_M2R  = 5;
    localparam int C_BR   = 4;
    localparam int C_J    = 3;
    localparam int C_IRW  = 2;
    localparam int C_PCW  = 1;
    localparam int C_ILL  = 0;

    typedef struct {
        logic [31:0] instr;
        logic        iready;
        logic        dready;
        int          st;
        logic [10:0] ctl;
        logic        chk_alu;
        logic [6:0]  aluop;
        logic        alusrc;
        logic        auipc;
        logic [63:0] imm;
        int          ret;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;

    logic        imem_req_a, dmem_req_a, RegWrite_a, ALUSrc_a, MemRead_a;
    logic        MemWrite_a, MemToReg_a, Branch_a, Jump_a, auipc_a;
    logic        ir_write_a, pc_write_a, illegal_a;
    logic [6:0]  ALUOp_a;
    logic [31:0] imm_a;
    logic [2:0]  state_a;
    logic [31:0] ret_a;

    logic        imem_req_b, dmem_req_b, RegWrite_b, ALUSrc_b, MemRead_b;
    logic        MemWrite_b, MemToReg_b, Branch_b, Jump_b, auipc_b;
    logic        ir_write_b, pc_write_b, illegal_b;
    logic [6:0]  ALUOp_b;
    logic [63:0] imm_b;
    logic [2:0]  state_b;
    logic [3:0]  ret_b;

    logic [10:0] ctl_a, ctl_b;

    int          checks = 0;
    int          errors = 0;
    rec_t        sched[$];
    rec_t        exp_q[$];
    logic [63:0] cur_imm = '0;
    int          cnt = 0;
    logic [6:0]  ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h67};

    multicycle_control_unit #(.XLEN(32), .ALUOP_W(7), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_req(imem_req_a), .imem_ready(imem_ready),
        .dmem_req(dmem_req_a), .dmem_ready(dmem_ready),
        .ALUOp(ALUOp_a), .RegWrite(RegWrite_a), .ALUSrc(ALUSrc_a),
        .MemRead(MemRead_a), .MemWrite(MemWrite_a), .MemToReg(MemToReg_a),
        .Branch(Branch_a), .Jump(Jump_a), .auipc(auipc_a), .imm(imm_a),
        .ir_write(ir_write_a), .pc_write(pc_write_a), .illegal(illegal_a),
        .state(state_a), .retired(ret_a)
    );

    multicycle_control_unit #(.XLEN(64), .ALUOP_W(7), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_req(imem_req_b), .imem_ready(imem_ready),
        .dmem_req(dmem_req_b), .dmem_ready(dmem_ready),
        .ALUOp(ALUOp_b), .RegWrite(RegWrite_b), .ALUSrc(ALUSrc_b),
        .MemRead(MemRead_b), .MemWrite(MemWrite_b), .MemToReg(MemToReg_b),
        .Branch(Branch_b), .Jump(Jump_b), .auipc(auipc_b), .imm(imm_b),
        .ir_write(ir_write_b), .pc_write(pc_write_b), .illegal(illegal_b),
        .state(state_b), .retired(ret_b)
    );

    assign ctl_a = {imem_req_a, dmem_req_a, RegWrite_a, MemRead_a,
                    MemWrite_a, MemToReg_a, Branch_a, Jump_a,
                    ir_write_a, pc_write_a, illegal_a};
    assign ctl_b = {imem_req_b, dmem_req_b, RegWrite_b, MemRead_b,
                    MemWrite_b, MemToReg_b, Branch_b, Jump_b,
                    ir_write_b, pc_write_b, illegal_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Instruction class: 0 R, 1 I-arith, 2 ld/st, 3 br, 4 LUI,
    // 5 AUIPC, 6 JAL/JALR, 7 illegal.
    function automatic int mclass(input logic [31:0] ir);
        case (ir[6:0])
            7'h33:        return 0;
            7'h13:        return 1;
            7'h03, 7'h23: return 2;
            7'h63:        return 3;
            7'h37:        return 4;
            7'h17:        return 5;
            7'h6F, 7'h67: return 6;
            default:      return 7;
        endcase
    endfunction

    function automatic logic [6:0] maluop(input logic [31:0] ir);
        int c;
        logic [2:0] f;
        logic b;
        logic [2:0] cc;
        c  = mclass(ir);
        f  = (c == 0 || c == 1 || c == 3) ? ir[14:12] : 3'b000;
        b  = (c == 0 || (c == 1 && ir[14:12] == 3'b101)) ? ir[30] : 1'b0;
        cc = 3'(c);
        return {b, f, cc};
    endfunction

    function automatic logic malusrc(input logic [31:0] ir);
        int c;
        c = mclass(ir);
        return (c == 1 || c == 2 || c == 4 || c == 5 || ir[6:0] == 7'h67);
    endfunction

    function automatic logic [63:0] mimm(input logic [31:0] ir);
        longint s;
        s = longint'($signed(ir));
        case (ir[6:0])
            7'h13, 7'h03, 7'h67: return s >>> 20;
            7'h23: return ((s >>> 25) << 5) | longint'(ir[11:7]);
            7'h63: return ((s >>> 31) << 12) | (longint'(ir[7]) << 11)
                        | (longint'(ir[30:25]) << 5)
                        | (longint'(ir[11:8]) << 1);
            7'h37, 7'h17: return (s >>> 12) << 12;
            7'h6F: return ((s >>> 31) << 20) | (longint'(ir[19:12]) << 12)
                        | (longint'(ir[20]) << 11)
                        | (longint'(ir[30:21]) << 1);
            default: return 64'd0;
        endcase
    endfunction

    function automatic rec_t base();
        rec_t r;
        r.instr   = $urandom;
        r.iready  = 1'($urandom);
        r.dready  = 1'($urandom);
        r.st      = 0;
        r.ctl     = '0;
        r.chk_alu = 1'b1;
        r.aluop   = '0;
        r.alusrc  = 1'b0;
        r.auipc   = 1'b0;
        r.imm     = cur_imm;
        r.ret     = cnt;
        return r;
    endfunction

    // Appends the expected cycle-by-cycle behaviour of one instruction.
    task automatic add_instr(input logic [31:0] ins, input int fw,
                             input int dw);
        rec_t r;
        int   c;
        logic ld, st, jmp;
        c   = mclass(ins);
        ld  = (ins[6:0] == 7'h03);
        st  = (ins[6:0] == 7'h23);
        jmp = (c == 6);
        for (int i = 0; i <= fw; i++) begin
            r = base();
            r.iready = (i == fw);
            if (i == fw) r.instr = ins;
            r.ctl[C_IREQ] = 1'b1;
            r.ctl[C_IRW]  = (i == fw);
            sched.push_back(r);
        end
        cur_imm = mimm(ins);
        r = base();
        r.st = 1;
        if (c == 7) begin
            r.ctl[C_ILL] = 1'b1;
            r.ctl[C_PCW] = 1'b1;
            sched.push_back(r);
            return;
        end
        sched.push_back(r);
        r = base();
        r.st       = 2;
        r.aluop    = maluop(ins);
        r.alusrc   = malusrc(ins);
        r.auipc    = (c == 5);
        r.ctl[C_J] = jmp;
        if (c == 3) begin
            r.ctl[C_BR]  = 1'b1;
            r.ctl[C_PCW] = 1'b1;
            sched.push_back(r);
            cnt++;
            return;
        end
        sched.push_back(r);
        if (ld || st) begin
            for (int j = 0; j <= dw; j++) begin
                r = base();
                r.st          = 3;
                r.chk_alu     = 1'b0;
                r.dready      = (j == dw);
                r.ctl[C_DREQ] = 1'b1;
                r.ctl[C_MR]   = ld;
                r.ctl[C_MW]   = st;
                r.ctl[C_PCW]  = st;
                sched.push_back(r);
            end
        end
        if (st) begin
            cnt++;
            return;
        end
        r = base();
        r.st         = 4;
        r.chk_alu    = 1'b0;
        r.ctl[C_RW]  = 1'b1;
        r.ctl[C_M2R] = ld;
        r.ctl[C_J]   = jmp;
        r.ctl[C_PCW] = 1'b1;
        sched.push_back(r);
        cnt++;
    endtask

    task automatic add_random(input int n);
        logic [31:0] x;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                do x = $urandom; while (mclass(x) != 7);
            end else begin
                x = $urandom;
                x[6:0] = ops[$urandom_range(0, 8)];
            end
            add_instr(x, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic run_sched();
        rec_t r;
        while (sched.size() > 0) begin
            r = sched.pop_front();
            instr      = r.instr;
            imem_ready = r.iready;
            dmem_ready = r.dready;
            exp_q.push_back(r);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        rec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", 64'(state_a), 64'(e.st));
            chk("state_b", 64'(state_b), 64'(e.st));
            chk("ctl", 64'(ctl_a), 64'(e.ctl));
            chk("ctl_b", 64'(ctl_b), 64'(e.ctl));
            chk("imm32", 64'(imm_a), 64'(e.imm[31:0]));
            chk("imm64", imm_b, e.imm);
            chk("retired", 64'(ret_a), 64'(e.ret));
            chk("retired_b", 64'(ret_b), 64'(e.ret % 16));
            if (e.chk_alu) begin
                chk("aluop", 64'({ALUOp_a, ALUSrc_a, auipc_a}),
                    64'({e.aluop, e.alusrc, e.auipc}));
                chk("aluop_b", 64'({ALUOp_b, ALUSrc_b, auipc_b}),
                    64'({e.aluop, e.alusrc, e.auipc}));
            end
        end
    end

    initial begin
        int n0;
        rst_n      = 1'b0;
        instr      = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        chk("model_imm_addi", mimm(32'h00500093), 64'd5);
        chk("model_imm_sw", mimm(32'hFE20AE23), 64'hFFFFFFFFFFFFFFFC);
        chk("model_imm_beq", mimm(32'h00000463), 64'd8);
        chk("model_aluop_addi", 64'(maluop(32'h00500093)), 64'h01);
        chk("model_aluop_lw", 64'(maluop(32'h0080A183)), 64'h02);
        chk("model_aluop_beq", 64'(maluop(32'h00000463)), 64'h03);

        n0 = sched.size();
        add_instr(32'h00500093, 0, 0);
        chk("len_addi", 64'(sched.size() - n0), 64'd4);
        n0 = sched.size();
        add_instr(32'h0080A183, 0, 3);
        chk("len_lw_wait3", 64'(sched.size() - n0), 64'd8);
        n0 = sched.size();
        add_instr(32'hFE20AE23, 0, 0);
        chk("len_sw", 64'(sched.size() - n0), 64'd4);
        n0 = sched.size();
        add_instr(32'h00000463, 0, 0);
        chk("len_beq", 64'(sched.size() - n0), 64'd3);
        n0 = sched.size();
        add_instr(32'hFFFFFFFF, 0, 0);
        chk("len_illegal", 64'(sched.size() - n0), 64'd2);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(state_a), 64'd0);
        chk("rst_ctl", 64'(ctl_a), 64'd0);
        chk("rst_retired", 64'(ret_a), 64'd0);
        chk("rst_imm", 64'(imm_a), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_imem_req", 64'(imem_req_a), 64'd1);

        run_sched();
        chk("directed_retired", 64'(ret_a), 64'd4);

        add_random(120);
        run_sched();

        // Reset in the middle of a stalled load.
        instr      = 32'h0080A183;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_mem_state", 64'(state_a), 64'd3);
        chk("mid_mem_dreq", 64'(dmem_req_a), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dreq", 64'(dmem_req_a), 64'd0);
        chk("arst_state", 64'(state_a), 64'd0);
        chk("arst_retired", 64'(ret_a), 64'd0);
        chk("arst_retired_b", 64'(ret_b), 64'd0);
        chk("arst_ctl", 64'(ctl_a), 64'd0);
        chk("arst_imm", imm_b, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("arel_imem_req", 64'(imem_req_a), 64'd1);
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        chk("late_ready_state", 64'(state_a), 64'd0);
        chk("late_ready_dreq", 64'(dmem_req_a), 64'd0);
        chk("late_ready_ret", 64'(ret_a), 64'd0);
        dmem_ready = 1'b0;
        cnt     = 0;
        cur_imm = '0;

        add_random(30);
        run_sched();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle RV32I/RV64I control unit. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives per-state datapath controls. Memory handshakes are variable-latency (req/ready). The instruction register and sign-extended immediate are XLEN-parametrised, and a retired-instruction counter is maintained. It replaces the single-cycle combinational controlUnit between the PC/IR and the register file/ALU/memory datapath.

## Interface
- XLEN, 32, datapath width; 32 or 64; sets imm width.
- ALUOP_W, 7, ALUOp width; fixed encoding below, must be 7.
- CNT_W, 32, width of retired counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word from instruction memory; sampled when imem_req & imem_ready.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  out  1  data memory request.
- dmem_ready  in  1  data access complete this cycle.
- ALUOp  out  ALUOP_W  {funct7b5, funct3[2:0], class[2:0]}.
- RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, Branch, Jump, auipc  out  1 each  datapath controls.
- imm  out  XLEN  sign-extended immediate of latched IR.
- ir_write, pc_write  out  1 each  IR load / PC update strobes.
- illegal  out  1  one-cycle pulse on undecodable opcode.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- retired  out  CNT_W  count of completed instructions; wraps to 0.

## Operation
- IR is a 32-bit register; it is loaded with instr when ir_write=1. All decode uses IR, never instr directly.
- Immediate formats are taken from IR, with bit 31 replicated to XLEN:
  - I: opcodes 0010011, 0000011, 1100111.
  - S: opcode 0100011.
  - B: opcode 1100011; bit0=0.
  - U: opcodes 0110111, 0010111; low 12 bits zero.
  - J: opcode 1101111.
  - Other opcodes: imm=0.
- ALUOp class field:
  - R=000
  - I-arith=001
  - load/store=010
  - branch=011
  - LUI=100
  - AUIPC=101
  - JAL/JALR=110
- ALUOp funct3 field is IR[14:12] for R, I-arith and branch; otherwise 000.
- ALUOp funct7b5 is IR[30]:
  - for R;
  - for I-arith only when funct3=101;
  - otherwise 0.
- FETCH: imem_req=1 until imem_ready=1. In that cycle ir_write=1 (combinational on imem_ready) and next state is DECODE.
- DECODE: all controls are 0. A legal opcode goes to EXEC. An illegal opcode pulses illegal=1, pulses pc_write=1 (skip), does not increment retired, and goes to FETCH.
- EXEC: ALUOp, ALUSrc and auipc are valid. The next state depends on class:
  - load/store goes to MEM.
  - branch asserts Branch=1 and pc_write=1 (datapath gates on compare), increments retired, and goes to FETCH.
  - all other classes go to WB.
  - Jump=1 for JAL/JALR in EXEC and WB.
- MEM: dmem_req=1, with MemRead=1 for a load or MemWrite=1 for a store, held until dmem_ready=1.
  - A load then goes to WB.
  - A store pulses pc_write, increments retired, and goes to FETCH.
- WB: RegWrite=1 and MemToReg=1 (for a load only), pc_write=1, retired+1, next state FETCH.
- ALUSrc=1 for I-arith, load/store, LUI, AUIPC and JALR; 0 for R and branch.
- Invariant: imem_req and dmem_req are never both 1.
- A request, once raised, stays high until its ready is seen. ready while the corresponding req=0 is ignored.
- Reset (any cycle, including mid-MEM with dmem_req high): state=FETCH, IR=0, retired=0. All outputs go to 0 immediately, except imem_req=1 once rst_n deasserts.

## Timing
- Control outputs are Moore functions of state and IR. ir_write is the only output combinational on an input (imem_ready).
- Latency with zero-wait memory:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - branch: 3 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- imm is valid from the cycle after ir_write until the next ir_write.
- retired updates on the clock edge that ends the completing state. Wrap from 2^CNT_W−1 goes to 0 with no flag.

## Test plan
- addi x1,x0,5 (0x00500093), imem_ready tied to 1 -> states 0,1,2,4,0; ALUOp=0000001; ALUSrc=1; imm=5; RegWrite=1 only in WB; retired 0→1 after 4 cycles.
- lw x3,8(x1) (0x0080A183), dmem_ready after 3 wait cycles -> dmem_req high 4 cycles; MemRead=1; imm=8; ALUOp=0000010; then WB with MemToReg=1; total 8 cycles.
- sw x2,-4(x1) (0xFE20AE23) with XLEN=32 -> imm=0xFFFFFFFC, MemWrite=1, no WB, RegWrite never 1. With XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
- beq x0,x0,+8 (0x00000463) -> imm=8; Branch=1 and pc_write=1 in EXEC only; ALUOp=0000011; returns to FETCH after 3 cycles; retired+1.
- instr=0xFFFFFFFF -> illegal=1 for one cycle in DECODE; pc_write=1; retired unchanged; next state FETCH.
- rst_n low for 1 cycle while in MEM with dmem_req=1 -> dmem_req drops without a clock edge; state=0; retired=0; imem_req=1 after release; a subsequent late dmem_ready is ignored.
